// File: rtl/apb2_master.sv
// APB2 initiator: turns command/write-data handshakes into APB2 bursts with an
// auto-incrementing address, and holds read data for upstream until accepted.
module apb2_master #(
    parameter int ADDR_BITS = 12,
    parameter int DATA_BITS = 8,
    parameter int LEN_BITS  = 4
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [LEN_BITS-1:0]  cmd_len,
    input  logic                 wdata_valid,
    output logic                 wdata_ready,
    input  logic [DATA_BITS-1:0] wdata,
    output logic                 rdata_valid,
    input  logic                 rdata_ready,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 done,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [ADDR_BITS-1:0] PADDR,
    output logic [DATA_BITS-1:0] PWDATA,
    input  logic [DATA_BITS-1:0] PRDATA
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PREP   = 2'd1,
        S_SETUP  = 2'd2,
        S_ACCESS = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_pwrite;
    logic [ADDR_BITS-1:0] r_paddr;
    logic [DATA_BITS-1:0] r_pwdata;
    logic [LEN_BITS-1:0]  r_cnt;
    logic [DATA_BITS-1:0] r_rdata;
    logic                 r_rdata_valid;
    logic                 r_done;

    logic w_cmd_fire;
    logic w_wdata_fire;
    logic w_capture;
    logic w_last;
    logic w_rd_blocked;

    assign w_cmd_fire   = cmd_valid && cmd_ready;
    assign w_wdata_fire = wdata_valid && wdata_ready;
    assign w_capture    = (r_state == S_ACCESS) && !r_pwrite;
    assign w_last       = (r_cnt == '0);
    // A read beat may not start while unaccepted read data would be overwritten.
    assign w_rd_blocked = r_rdata_valid && !rdata_ready;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (cmd_valid) w_state_next = S_PREP;
            S_PREP: begin
                if (r_pwrite) begin
                    if (wdata_valid) w_state_next = S_SETUP;
                end else if (!w_rd_blocked) begin
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP:  w_state_next = S_ACCESS;
            S_ACCESS: w_state_next = w_last ? S_IDLE : S_PREP;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = (r_state == S_IDLE);
        wdata_ready = (r_state == S_PREP) && r_pwrite;
        PSEL        = (r_state == S_SETUP) || (r_state == S_ACCESS);
        PENABLE     = (r_state == S_ACCESS);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_cnt         <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= (r_state == S_ACCESS) && w_last;
            if (w_cmd_fire) begin
                r_pwrite <= cmd_write;
                r_paddr  <= cmd_addr;
                r_cnt    <= cmd_len;
            end
            if (w_wdata_fire) r_pwdata <= wdata;
            if ((r_state == S_ACCESS) && !w_last) begin
                r_cnt   <= r_cnt - LEN_BITS'(1);
                r_paddr <= r_paddr + ADDR_BITS'(1);
            end
            // A fresh capture takes priority over an accept in the same cycle.
            if (w_capture) begin
                r_rdata       <= PRDATA;
                r_rdata_valid <= 1'b1;
            end else if (r_rdata_valid && rdata_ready) begin
                r_rdata_valid <= 1'b0;
            end
        end
    end

    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign done        = r_done;

endmodule

// File: tb/tb_apb2_master.sv
// Bench for apb2_master: directed bursts with queued expectations checked by a
// negedge monitor, plus cycle-exact checks on latency, stalls and reset abort.
module tb_apb2_master;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [7:0]  wdata;
    logic        rdata_valid, rdata_ready;
    logic [7:0]  rdata;
    logic        done;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [7:0]  PWDATA, PRDATA;

    logic [7:0]  mem [0:4095];

    typedef struct packed {
        logic        w;
        logic [11:0] a;
        logic [7:0]  d;
    } apb_t;

    apb_t        apb_q[$];
    logic [7:0]  rd_q[$];
    int          checks = 0;
    int          failures = 0;
    int          done_seen = 0;
    int          done_exp = 0;
    logic        prev_setup = 1'b0;
    logic [11:0] prev_addr = '0;

    always #5 PCLK = ~PCLK;
    assign PRDATA = mem[PADDR];

    apb2_master #(.ADDR_BITS(12), .DATA_BITS(8), .LEN_BITS(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .done(done),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes an APB transfer or
    // hands read data upstream.
    always @(negedge PCLK) begin
        apb_t e;
        logic [7:0] rexp;
        if (PSEL && PENABLE) begin
            chk("penable_after_setup", int'(prev_setup), 1);
            chk("paddr_stable", int'(PADDR), int'(prev_addr));
            if (apb_q.size() == 0) begin
                chk("apb_unexpected", 1, 0);
            end else begin
                e = apb_q.pop_front();
                chk("apb_pwrite", int'(PWRITE), int'(e.w));
                chk("apb_paddr", int'(PADDR), int'(e.a));
                if (e.w) chk("apb_pwdata", int'(PWDATA), int'(e.d));
                $display("APB %s addr=%03h data=%02h", PWRITE ? "WR" : "RD", PADDR,
                         PWRITE ? PWDATA : PRDATA);
            end
        end
        if (rdata_valid && rdata_ready) begin
            if (rd_q.size() == 0) begin
                chk("rdata_unexpected", 1, 0);
            end else begin
                rexp = rd_q.pop_front();
                chk("rdata_value", int'(rdata), int'(rexp));
                $display("RDATA accepted %02h", rdata);
            end
        end
        if (done) done_seen++;
        prev_setup = PSEL && !PENABLE;
        prev_addr  = PADDR;
    end

    task automatic issue(input logic w, input logic [11:0] a, input logic [3:0] l);
        int k;
        k = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        while (!cmd_ready && k < 200) begin tick(); k++; end
        chk("cmd_accept_timeout", int'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_wdata(input logic [7:0] d);
        int k;
        k = 0;
        wdata = d; wdata_valid = 1'b1;
        while (!wdata_ready && k < 200) begin tick(); k++; end
        chk("wdata_accept_timeout", int'(wdata_ready), 1);
        tick();
        wdata_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 200) begin tick(); k++; end
        chk("done_timeout", int'(done), 1);
    endtask

    task automatic push_apb(input logic w, input logic [11:0] a, input logic [7:0] d);
        apb_t e;
        e.w = w; e.a = a; e.d = d;
        apb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int d0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h040] = 8'h3C;
        mem[12'hFFE] = 8'h11; mem[12'hFFF] = 8'h22;
        mem[12'h000] = 8'h33; mem[12'h001] = 8'h44;
        mem[12'h300] = 8'h9A; mem[12'h301] = 8'hB7;

        PRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
        tick(); tick();
        PRESETn = 1'b1;
        tick();

        // Reset in the middle of ACCESS aborts the write without a clock edge.
        wdata = 8'h77; wdata_valid = 1'b1;
        issue(1'b1, 12'h010, 4'd0);
        k = 0;
        while (!(PSEL && PENABLE) && k < 50) begin tick(); k++; end
        chk("reset_reach_access", int'(PSEL && PENABLE), 1);
        PRESETn = 1'b0;
        wdata_valid = 1'b0;
        #1;
        chk("async_rst_psel", int'(PSEL), 0);
        chk("async_rst_penable", int'(PENABLE), 0);
        tick();
        PRESETn = 1'b1;
        #2;
        chk("rst_pwrite", int'(PWRITE), 0);
        chk("rst_paddr", int'(PADDR), 0);
        chk("rst_pwdata", int'(PWDATA), 0);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_rdata_valid", int'(rdata_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wdata_ready", int'(wdata_ready), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        $display("RESET abort and release checked");
        tick();

        // Single write with data ready up front.
        push_apb(1'b1, 12'h123, 8'hA5); done_exp++;
        wdata = 8'hA5; wdata_valid = 1'b1;
        chk("idle_wdata_ready", int'(wdata_ready), 0);
        issue(1'b1, 12'h123, 4'd0);
        chk("w1_prep_wready", int'(wdata_ready), 1);
        chk("w1_prep_psel", int'(PSEL), 0);
        tick(); wdata_valid = 1'b0;
        chk("w1_setup_psel", int'(PSEL), 1);
        chk("w1_setup_penable", int'(PENABLE), 0);
        chk("w1_setup_paddr", int'(PADDR), 12'h123);
        chk("w1_setup_pwdata", int'(PWDATA), 8'hA5);
        chk("w1_cmd_ready_busy", int'(cmd_ready), 0);
        tick();
        chk("w1_access_penable", int'(PENABLE), 1);
        tick();
        chk("w1_done", int'(done), 1);
        chk("w1_cmd_ready", int'(cmd_ready), 1);
        chk("w1_psel_low", int'(PSEL), 0);

        // Single read, data held until upstream takes it.
        push_apb(1'b0, 12'h040, 8'h00); rd_q.push_back(8'h3C); done_exp++;
        issue(1'b0, 12'h040, 4'd0);
        tick(); tick(); tick();
        chk("r1_done", int'(done), 1);
        chk("r1_rvalid", int'(rdata_valid), 1);
        chk("r1_rdata", int'(rdata), 8'h3C);
        chk("r1_pwdata_kept", int'(PWDATA), 8'hA5);
        tick(); tick(); tick();
        chk("r1_rvalid_hold", int'(rdata_valid), 1);
        rdata_ready = 1'b1;
        tick();
        chk("r1_rvalid_clear", int'(rdata_valid), 0);
        rdata_ready = 1'b0;

        // Read burst wrapping the address space, stalled by upstream backpressure.
        push_apb(1'b0, 12'hFFE, 8'h00); push_apb(1'b0, 12'hFFF, 8'h00);
        push_apb(1'b0, 12'h000, 8'h00); push_apb(1'b0, 12'h001, 8'h00);
        rd_q.push_back(8'h11); rd_q.push_back(8'h22);
        rd_q.push_back(8'h33); rd_q.push_back(8'h44);
        done_exp++;
        issue(1'b0, 12'hFFE, 4'd3);
        k = 0;
        while (!rdata_valid && k < 50) begin tick(); k++; end
        chk("rb_first_valid", int'(rdata_valid), 1);
        for (int i = 0; i < 4; i++) begin
            chk("rb_stall_psel", int'(PSEL), 0);
            chk("rb_stall_paddr", int'(PADDR), 12'hFFF);
            tick();
        end
        rdata_ready = 1'b1;
        wait_done();
        chk("rb_final_paddr", int'(PADDR), 12'h001);
        tick(); tick();
        rdata_ready = 1'b0;

        // Write burst with a gap in upstream write data before beat 2.
        push_apb(1'b1, 12'h200, 8'h5A); push_apb(1'b1, 12'h201, 8'h6B);
        push_apb(1'b1, 12'h202, 8'h7C); done_exp++;
        d0 = done_seen;
        issue(1'b1, 12'h200, 4'd2);
        send_wdata(8'h5A);
        k = 0;
        while (!wdata_ready && k < 50) begin tick(); k++; end
        chk("wb_beat2_prep", int'(wdata_ready), 1);
        for (int i = 0; i < 5; i++) begin
            chk("wb_gap_psel", int'(PSEL), 0);
            tick();
        end
        send_wdata(8'h6B);
        send_wdata(8'h7C);
        wait_done();
        tick(); tick();
        chk("wb_done_once", done_seen - d0, 1);

        // Command held valid across a 2-beat read: next accept only with done.
        push_apb(1'b0, 12'h300, 8'h00); push_apb(1'b0, 12'h301, 8'h00);
        push_apb(1'b0, 12'h300, 8'h00); push_apb(1'b0, 12'h301, 8'h00);
        rd_q.push_back(8'h9A); rd_q.push_back(8'hB7);
        rd_q.push_back(8'h9A); rd_q.push_back(8'hB7);
        done_exp += 2;
        rdata_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h300; cmd_len = 4'd1;
        chk("cb_first_ready", int'(cmd_ready), 1);
        tick();
        k = 1;
        while (!cmd_ready && k < 30) begin tick(); k++; end
        chk("cb_second_accept_cycle", k, 7);
        chk("cb_accept_with_done", int'(done), 1);
        tick();
        cmd_valid = 1'b0;
        chk("cb_second_taken", int'(cmd_ready), 0);
        wait_done();
        tick(); tick();
        rdata_ready = 1'b0;

        tick(); tick();
        chk("end_apb_queue_empty", apb_q.size(), 0);
        chk("end_rd_queue_empty", rd_q.size(), 0);
        chk("end_done_count", done_seen, done_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
